// File: rtl/ysyx_24100006_exe_mem.sv
// EXE -> MEM pipeline register with valid/ready handshakes on both sides.
// Define YSYX_24100006_EXE_MEM_SKID_EN for the two-entry build with a registered upstream ready.
module ysyx_24100006_exe_mem #(
    parameter int PAYLOAD_W = 238
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exe_in_valid,
    output logic                 exe_in_ready,
    input  logic [PAYLOAD_W-1:0] exe_payload_i,
    input  logic                 flush,
    output logic                 mem_out_valid,
    input  logic                 mem_out_ready,
    output logic [PAYLOAD_W-1:0] mem_payload_o,
    output logic [1:0]           occupancy
);

`ifdef YSYX_24100006_EXE_MEM_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;
`else
    typedef enum logic {
        EMPTY = 1'b0,
        ONE   = 1'b1
    } state_t;
`endif

    state_t               state;
    logic                 main_valid;
    logic [PAYLOAD_W-1:0] main_data;
    logic [1:0]           occ;
    logic                 in_fire;
    logic                 out_fire;

    assign in_fire       = exe_in_valid & exe_in_ready;
    assign out_fire      = main_valid & mem_out_ready;
    assign mem_out_valid = main_valid;
    assign mem_payload_o = main_data;
    assign occupancy     = occ;

`ifdef YSYX_24100006_EXE_MEM_SKID_EN
    logic                 ready_q;
    logic [PAYLOAD_W-1:0] skid_data;

    // ready_q mirrors "skid entry empty" so upstream ready never sees mem_out_ready
    assign exe_in_ready = ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            ready_q    <= 1'b1;
            occ        <= 2'd0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            ready_q    <= 1'b1;
            occ        <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data  <= exe_payload_i;
                        main_valid <= 1'b1;
                        occ        <= 2'd1;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data <= exe_payload_i;
                    end else if (in_fire) begin
                        skid_data <= exe_payload_i;
                        ready_q   <= 1'b0;
                        occ       <= 2'd2;
                        state     <= FULL;
                    end else if (out_fire) begin
                        main_valid <= 1'b0;
                        occ        <= 2'd0;
                        state      <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_data <= skid_data;
                        ready_q   <= 1'b1;
                        occ       <= 2'd1;
                        state     <= ONE;
                    end
                end
                default: begin
                    main_valid <= 1'b0;
                    ready_q    <= 1'b1;
                    occ        <= 2'd0;
                    state      <= EMPTY;
                end
            endcase
        end
    end
`else
    // Single entry: a held beat can only be replaced in the cycle it drains
    assign exe_in_ready = ~main_valid | mem_out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            occ        <= 2'd0;
            main_data  <= '0;
        end else if (flush) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            occ        <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data  <= exe_payload_i;
                        main_valid <= 1'b1;
                        occ        <= 2'd1;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (out_fire) begin
                        if (in_fire) begin
                            main_data <= exe_payload_i;
                        end else begin
                            main_valid <= 1'b0;
                            occ        <= 2'd0;
                            state      <= EMPTY;
                        end
                    end
                end
                default: begin
                    main_valid <= 1'b0;
                    occ        <= 2'd0;
                    state      <= EMPTY;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24100006_exe_mem.sv
// Self-checking bench for ysyx_24100006_exe_mem; follows YSYX_24100006_EXE_MEM_SKID_EN like the design.
module tb_ysyx_24100006_exe_mem;

`ifdef YSYX_24100006_EXE_MEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int W = 238;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         exe_in_valid = 1'b0;
    logic         exe_in_ready;
    logic [W-1:0] exe_payload_i = '0;
    logic         flush = 1'b0;
    logic         mem_out_valid;
    logic         mem_out_ready = 1'b0;
    logic [W-1:0] mem_payload_o;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    ysyx_24100006_exe_mem #(.PAYLOAD_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .exe_in_valid  (exe_in_valid),
        .exe_in_ready  (exe_in_ready),
        .exe_payload_i (exe_payload_i),
        .flush         (flush),
        .mem_out_valid (mem_out_valid),
        .mem_out_ready (mem_out_ready),
        .mem_payload_o (mem_payload_o),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        bit          rst;
        bit          vin;
        logic [31:0] pc;
        bit          mrdy;
        bit          fl;
        bit          ev;
        logic [31:0] epc;
        logic [1:0]  eocc;
        bit          erdy;
    } vec_t;

    function automatic vec_t v(bit rst, bit vin, logic [31:0] pc, bit mrdy, bit fl,
                               bit ev, logic [31:0] epc, logic [1:0] eocc, bit erdy);
        vec_t r;
        r.rst = rst; r.vin = vin; r.pc = pc; r.mrdy = mrdy; r.fl = fl;
        r.ev = ev; r.epc = epc; r.eocc = eocc; r.erdy = erdy;
        return r;
    endfunction

    function automatic logic [W-1:0] mk(input logic [31:0] pc);
        return {pc, pc ^ 32'h5a5a5a5a, pc, ~pc, pc, pc + 32'd1, pc, pc[13:0]};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input bit rst, input bit vin, input logic [31:0] pc,
                         input bit mrdy, input bit fl);
        @(negedge clk);
        reset = rst;
        exe_in_valid = vin;
        exe_payload_i = mk(pc);
        mem_out_ready = mrdy;
        flush = fl;
        #1;
    endtask

    vec_t            tbl[16];
    logic [31:0]     send[3];
    logic [W-1:0]    got[$];
    logic [W-1:0]    q[$];
    int              idx;

    initial begin
        // Streaming, simultaneous fire, flush in ONE, reset with a held beat
        tbl[0]  = v(0, 1, 32'h80000000, 1, 0, 0, 32'h0,        2'd0, 1);
        tbl[1]  = v(0, 1, 32'h80000004, 1, 0, 1, 32'h80000000, 2'd1, 1);
        tbl[2]  = v(0, 1, 32'h80000008, 1, 0, 1, 32'h80000004, 2'd1, 1);
        tbl[3]  = v(0, 1, 32'h8000000C, 1, 0, 1, 32'h80000008, 2'd1, 1);
        tbl[4]  = v(0, 0, 32'h0,        1, 0, 1, 32'h8000000C, 2'd1, 1);
        tbl[5]  = v(0, 0, 32'h0,        1, 0, 0, 32'h0,        2'd0, 1);
        tbl[6]  = v(0, 1, 32'h200,      1, 0, 0, 32'h0,        2'd0, 1);
        tbl[7]  = v(0, 1, 32'h204,      1, 0, 1, 32'h200,      2'd1, 1);
        tbl[8]  = v(0, 1, 32'h208,      1, 0, 1, 32'h204,      2'd1, 1);
        tbl[9]  = v(0, 1, 32'h20C,      1, 0, 1, 32'h208,      2'd1, 1);
        tbl[10] = v(0, 0, 32'h0,        0, 0, 1, 32'h20C,      2'd1, SKID);
        tbl[11] = v(0, 0, 32'h0,        0, 1, 1, 32'h20C,      2'd1, SKID);
        tbl[12] = v(0, 0, 32'h0,        1, 0, 0, 32'h0,        2'd0, 1);
        tbl[13] = v(0, 1, 32'h300,      0, 0, 0, 32'h0,        2'd0, 1);
        tbl[14] = v(1, 0, 32'h0,        0, 0, 1, 32'h300,      2'd1, SKID);
        tbl[15] = v(0, 0, 32'h0,        1, 0, 0, 32'h0,        2'd0, 1);

        // Reset held for two edges
        drive(1, 0, 32'h0, 0, 0);
        drive(1, 0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        chk("rst_valid", mem_out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_payload", mem_payload_o, 0);
        chk("rst_ready", exe_in_ready, 1);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].vin, tbl[i].pc, tbl[i].mrdy, tbl[i].fl);
            chk($sformatf("tbl%0d_valid", i), mem_out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].eocc);
            chk($sformatf("tbl%0d_ready", i), exe_in_ready, tbl[i].erdy);
            if (tbl[i].ev)
                chk($sformatf("tbl%0d_payload", i), mem_payload_o, mk(tbl[i].epc));
        end
        chk("post_reset_payload", mem_payload_o, 0);

        // Backpressure: A and B under stall, C held by EXEU until accepted
        send[0] = 32'h100; send[1] = 32'h104; send[2] = 32'h108;
        idx = 0;
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            drive(0, idx < 3, (idx < 3) ? send[idx] : 32'h0, c >= 4, 0);
            if (c == 3) begin
                chk("bp_occ", occupancy, SKID ? 2'd2 : 2'd1);
                chk("bp_ready", exe_in_ready, 0);
                chk("bp_head", mem_payload_o, mk(send[0]));
            end
            if (mem_out_valid && mem_out_ready) got.push_back(mem_payload_o);
            if (exe_in_valid && exe_in_ready) idx++;
        end
        chk("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("bp_order%0d", k), (k < got.size()) ? got[k] : '0, mk(send[k]));
        drive(0, 0, 32'h0, 1, 0);
        chk("bp_no_dup", mem_out_valid, 0);

        // Flush with a beat on offer: that beat must never appear
        drive(0, 1, 32'h400, 0, 0);
        drive(0, 1, 32'h404, 0, 0);
        drive(0, 1, 32'h408, 0, 1);
        chk("fl_pre_occ", occupancy, SKID ? 2'd2 : 2'd1);
        drive(0, 0, 32'h0, 1, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", mem_out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 32'h0, 1, 0);
            chk($sformatf("fl_gone%0d", k), mem_out_valid, 0);
        end

        // Upstream ready against a same-cycle change of mem_out_ready
        drive(0, 1, 32'h500, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        chk("cr_occ", occupancy, 1);
        chk("cr_ready_lo", exe_in_ready, SKID);
        mem_out_ready = 1'b1;
        #1;
        chk("cr_ready_hi", exe_in_ready, 1);
        drive(0, 0, 32'h0, 1, 0);
        chk("cr_drained", mem_out_valid, 0);

        // Random traffic against a FIFO model of capacity 2 (skid) or 1
        q.delete();
        for (int n = 0; n < 1500; n++) begin
            logic [255:0] w;
            bit rst, fl, vin, mrdy, erdy, ev;
            w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rst  = ($urandom_range(0, 96) == 0);
            fl   = ($urandom_range(0, 40) == 0);
            vin  = ($urandom_range(0, 3) != 0);
            mrdy = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            reset = rst; flush = fl; exe_in_valid = vin; mem_out_ready = mrdy;
            exe_payload_i = w[W-1:0];
            #1;
            ev   = (q.size() > 0);
            erdy = SKID ? (q.size() < 2) : (q.size() == 0 || mrdy);
            chk("rnd_valid", mem_out_valid, ev);
            chk("rnd_occ", occupancy, q.size());
            chk("rnd_ready", exe_in_ready, erdy);
            if (ev) chk("rnd_payload", mem_payload_o, q[0]);
            if (rst || fl) begin
                q.delete();
            end else begin
                if (ev && mrdy) void'(q.pop_front());
                if (vin && erdy) q.push_back(w[W-1:0]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
